sblk_row_dispatch: RTL

SBLK_ROW_DISPATCH -- requirements
Module: sblk_row_dispatch

---
 rtl/sblk_row_dispatch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sblk_row_dispatch.sv
// Superblock row dispatcher: queues {inst, mask} commands and issues each one
// to all of its target rows at once, waiting until none of them is pending or busy.
module sblk_row_dispatch #(
    parameter int N_ROW      = 7,
    parameter int WID_INST   = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int WID_CNT    = 16
) (
    input  logic                      clk_h,
    input  logic                      rst,
    input  logic [WID_INST-1:0]       cmd_inst,
    input  logic [N_ROW-1:0]          cmd_mask,
    input  logic                      cmd_vld,
    output logic                      cmd_rdy,
    input  logic [N_ROW-1:0]          status_sblk,
    output logic [WID_INST*N_ROW-1:0] inst_data,
    output logic [N_ROW-1:0]          inst_en,
    output logic                      idle,
    output logic                      err_empty_mask,
    output logic [WID_CNT-1:0]        issued_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WID_INST + N_ROW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2
    } state_t;

    logic [EW-1:0]             mem_q [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    state_t                    state_q, state_d;
    logic [N_ROW-1:0]          pending_q, pending_d;
    logic [N_ROW-1:0]          inst_en_q, inst_en_d;
    logic [WID_INST*N_ROW-1:0] inst_data_q, inst_data_d;
    logic                      err_q, err_d;
    logic [WID_CNT-1:0]        cnt_q, cnt_d;

    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic                      evaluate;
    logic                      issue;
    logic                      discard;
    logic [WID_INST-1:0]       head_inst;
    logic [N_ROW-1:0]          head_mask;
    logic [N_ROW-1:0]          avail;

    always_comb begin
        full      = (count_q == CW'(FIFO_DEPTH));
        empty     = (count_q == '0);
        push      = cmd_vld && !full;
        head_inst = mem_q[rd_ptr_q][EW-1:N_ROW];
        head_mask = mem_q[rd_ptr_q][N_ROW-1:0];
        avail     = ~pending_q & ~status_sblk;
        // ISSUE is the strobe cycle, so the head is never looked at twice in a row
        evaluate  = (state_q != ISSUE) && !empty;
        discard   = evaluate && (head_mask == '0);
        issue     = evaluate && (head_mask != '0) && ((head_mask & ~avail) == '0);
        pop       = issue || discard;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);
        err_d       = err_q || (push && (cmd_mask == '0));
        cnt_d       = cnt_q + WID_CNT'(issue);
        inst_en_d   = issue ? head_mask : '0;
        inst_data_d = inst_data_q;
        for (int i = 0; i < N_ROW; i++) begin
            if (issue && head_mask[i]) begin
                inst_data_d[i*WID_INST +: WID_INST] = head_inst;
            end
        end
        // a fresh issue, or the strobe cycle itself, wins over a busy-clear
        pending_d = (pending_q & ~status_sblk) | inst_en_d | inst_en_q;
        state_d   = state_q;
        unique case (state_q)
            IDLE, CHECK: begin
                if (issue) begin
                    state_d = ISSUE;
                end else if (empty) begin
                    state_d = IDLE;
                end else begin
                    state_d = CHECK;
                end
            end
            ISSUE:   state_d = empty ? IDLE : CHECK;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_h) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            pending_q   <= '0;
            inst_en_q   <= '0;
            inst_data_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            pending_q   <= pending_d;
            inst_en_q   <= inst_en_d;
            inst_data_q <= inst_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk_h) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_inst, cmd_mask};
        end
    end

    assign cmd_rdy        = !full;
    assign inst_en        = inst_en_q;
    assign inst_data      = inst_data_q;
    assign err_empty_mask = err_q;
    assign issued_cnt     = cnt_q;
    assign idle           = empty && (pending_q == '0) && (status_sblk == '0);

endmodule
